// File: rtl/deadlock_window_monitor.sv
// Declares deadlock when every instance is idle or blocked with an unchanged block pattern for WINDOW cycles.
// Latency: block rises on the WINDOW-th consecutive stalled edge; DEADLOCK_MONITOR_REPORT_EN adds a sim-only report line.
// Backpressure: none, observe-only; any axis_block_sigs bit vetoes the stall, and block is sticky until clear.
module deadlock_window_monitor #(
   parameter int NUM_INST = 14,
   parameter int NUM_AXIS = 2,
   parameter int WINDOW   = 16,
   parameter int IDX_W    = 6
) (
   input  logic                kernel_monitor_clock,
   input  logic                kernel_monitor_reset,
   input  logic [NUM_AXIS-1:0] axis_block_sigs,
   input  logic [NUM_INST-1:0] inst_idle_sigs,
   input  logic [NUM_INST-1:0] inst_block_sigs,
   input  logic                clear,
   output logic                block,
   output logic                watching,
   output logic [IDX_W-1:0]    first_blk_idx,
   output logic [NUM_INST-1:0] blk_snapshot
);

   typedef enum logic [1:0] {S_IDLE, S_WATCH, S_DEAD} state_t;

   state_t              state;
   logic [15:0]         cnt;
   logic [NUM_INST-1:0] sig;
   logic [NUM_INST-1:0] active;
   logic                stall_now;
   logic                progress;
   logic                win_done;
   logic                enter_dead;
   logic [IDX_W-1:0]    low_idx;

   // An instance that is both idle and blocked is not holding anything up.
   assign active     = inst_block_sigs & ~inst_idle_sigs;
   assign stall_now  = (&(inst_idle_sigs | inst_block_sigs)) && (|active) && !(|axis_block_sigs);
   assign progress   = (inst_block_sigs != sig);
   assign win_done   = (cnt >= 16'(WINDOW - 1));
   assign enter_dead = (state == S_WATCH) && !clear && stall_now && !progress && win_done;

   always_comb begin
      low_idx = '0;
      for (int i = NUM_INST - 1; i >= 0; i--) begin
         if (active[i]) low_idx = IDX_W'(i);
      end
   end

   always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
      if (!kernel_monitor_reset) begin
         state         <= S_IDLE;
         cnt           <= '0;
         sig           <= '0;
         block         <= 1'b0;
         watching      <= 1'b0;
         first_blk_idx <= '0;
         blk_snapshot  <= '0;
      end else if (clear) begin
         state    <= S_IDLE;
         cnt      <= '0;
         block    <= 1'b0;
         watching <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (stall_now) begin
                  state    <= S_WATCH;
                  cnt      <= 16'd1;
                  sig      <= inst_block_sigs;
                  watching <= 1'b1;
               end
            end
            S_WATCH: begin
               if (!stall_now) begin
                  state    <= S_IDLE;
                  cnt      <= '0;
                  watching <= 1'b0;
               end else if (progress) begin
                  cnt <= 16'd1;
                  sig <= inst_block_sigs;
               end else if (enter_dead) begin
                  state         <= S_DEAD;
                  watching      <= 1'b0;
                  block         <= 1'b1;
                  first_blk_idx <= low_idx;
                  blk_snapshot  <= inst_block_sigs;
               end else if (cnt != 16'hFFFF) begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_DEAD: begin
               state <= S_DEAD;
            end
            default: begin
               state    <= S_IDLE;
               cnt      <= '0;
               block    <= 1'b0;
               watching <= 1'b0;
            end
         endcase
      end
   end

`ifdef DEADLOCK_MONITOR_REPORT_EN
   always @(posedge kernel_monitor_clock) begin
      if (kernel_monitor_reset && enter_dead)
         $display("[%0t] deadlock_window_monitor: deadlock first_blk_idx=%0h blk_snapshot=%0h",
                  $time, low_idx, inst_block_sigs);
   end
`else
`endif

endmodule

// File: tb/tb_deadlock_window_monitor.sv
// Directed bench for deadlock_window_monitor: NUM_INST=4, WINDOW=16, plus a WINDOW=2 instance on shared inputs.
module tb_deadlock_window_monitor;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] axis;
   logic [3:0] idle;
   logic [3:0] blk;
   logic       clear;
   logic       block, watching;
   logic [1:0] idx;
   logic [3:0] snap;
   logic       block2, watching2;
   logic [1:0] idx2;
   logic [3:0] snap2;
   int         tests = 0;
   int         fails = 0;

   always #5 clk = ~clk;

   deadlock_window_monitor #(.NUM_INST(4), .NUM_AXIS(2), .WINDOW(16), .IDX_W(2)) u_dut (
      .kernel_monitor_clock(clk),
      .kernel_monitor_reset(rst_n),
      .axis_block_sigs(axis),
      .inst_idle_sigs(idle),
      .inst_block_sigs(blk),
      .clear(clear),
      .block(block),
      .watching(watching),
      .first_blk_idx(idx),
      .blk_snapshot(snap)
   );

   deadlock_window_monitor #(.NUM_INST(4), .NUM_AXIS(2), .WINDOW(2), .IDX_W(2)) u_w2 (
      .kernel_monitor_clock(clk),
      .kernel_monitor_reset(rst_n),
      .axis_block_sigs(axis),
      .inst_idle_sigs(idle),
      .inst_block_sigs(blk),
      .clear(clear),
      .block(block2),
      .watching(watching2),
      .first_blk_idx(idx2),
      .blk_snapshot(snap2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Steps edges start..16 of a stalled window; edge 16 must declare.
   task automatic run_window(input int start, input logic [1:0] eidx, input logic [3:0] esnap);
      for (int k = start; k <= 16; k++) begin
         step();
         if (k < 16) begin
            chk("window_watching", watching, 1);
            chk("window_block", block, 0);
         end else begin
            chk("declare_block", block, 1);
            chk("declare_watching", watching, 0);
            chk("declare_idx", idx, eidx);
            chk("declare_snap", snap, esnap);
         end
      end
   endtask

   task automatic clear_to_idle();
      idle  = 4'hF;
      blk   = 4'h0;
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("cleared_block", block, 0);
      chk("cleared_watching", watching, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      axis  = 2'b00;
      idle  = 4'h0;
      blk   = 4'h0;
      clear = 1'b0;
      #1;
      chk("reset_block", block, 0);
      chk("reset_watching", watching, 0);
      chk("reset_idx", idx, 0);
      chk("reset_snap", snap, 0);
      step();
      step();
      rst_n = 1'b1;

      // All idle never stalls.
      idle = 4'hF;
      for (int k = 0; k < 20; k++) begin
         step();
         chk("all_idle_watching", watching, 0);
         chk("all_idle_block", block, 0);
      end

      // One running instance (neither idle nor blocked) vetoes the stall.
      idle = 4'b0001;
      blk  = 4'b0110;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("running_inst_watching", watching, 0);
      end

      // Blocked-but-idle instance alone is not a stall.
      idle = 4'hF;
      blk  = 4'b0001;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("idle_blocked_watching", watching, 0);
      end

      // Constant stall: watch on edge 1, declare on edge 16; WINDOW=2 declares on edge 2.
      idle = 4'b1001;
      blk  = 4'b0110;
      step();
      chk("w16_watch_edge1", watching, 1);
      chk("w2_watch_edge1", watching2, 1);
      chk("w2_block_edge1", block2, 0);
      step();
      chk("w2_block_edge2", block2, 1);
      chk("w2_idx", idx2, 1);
      chk("w2_snap", snap2, 4'h6);
      chk("w16_watch_edge2", watching, 1);
      run_window(3, 2'd1, 4'h6);

      // Sticky while inputs go quiet.
      idle = 4'hF;
      blk  = 4'h0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("sticky_block", block, 1);
      end

      // Clear with stall present: drops, captures hold, then a full window again.
      idle  = 4'b1001;
      blk   = 4'b0110;
      step();
      chk("dead_hold_block", block, 1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clear_block", block, 0);
      chk("clear_watching", watching, 0);
      chk("clear_idx_hold", idx, 1);
      chk("clear_snap_hold", snap, 4'h6);
      run_window(1, 2'd1, 4'h6);
      clear_to_idle();

      // Pattern change at cycle 10 restarts the window.
      idle = 4'b1001;
      blk  = 4'b0110;
      for (int k = 1; k <= 10; k++) step();
      chk("pre_change_watching", watching, 1);
      idle = 4'b1011;
      blk  = 4'b0100;
      run_window(1, 2'd2, 4'h4);
      clear_to_idle();

      // Environment stall at cycle 8 abandons the window.
      idle = 4'b1001;
      blk  = 4'b0110;
      for (int k = 1; k <= 8; k++) step();
      chk("pre_axis_watching", watching, 1);
      axis = 2'b01;
      step();
      chk("axis_watching", watching, 0);
      chk("axis_block", block, 0);
      for (int k = 0; k < 20; k++) begin
         step();
         chk("axis_hold_watching", watching, 0);
         chk("axis_hold_block", block, 0);
      end
      axis = 2'b00;
      clear_to_idle();

      // Async reset mid-window at cycle 12, then a full window after release.
      idle = 4'b1001;
      blk  = 4'b0110;
      for (int k = 1; k <= 12; k++) step();
      chk("pre_reset_watching", watching, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_watching", watching, 0);
      chk("async_reset_block", block, 0);
      chk("async_reset_idx", idx, 0);
      chk("async_reset_snap", snap, 0);
      step();
      step();
      chk("in_reset_watching", watching, 0);
      rst_n = 1'b1;
      run_window(1, 2'd1, 4'h6);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/deadlock_window_monitor.md
DEADLOCK_WINDOW_MONITOR -- requirements
Module: deadlock_window_monitor

Interface
REQ-001 SHALL have parameter NUM_INST, default 14, meaning number of monitored dataflow process instances (1..64).
REQ-002 SHALL have parameter NUM_AXIS, default 2, meaning number of monitored top-level AXIS ports (1..16).
REQ-003 SHALL have parameter WINDOW, default 16, meaning consecutive stalled cycles required to declare deadlock (2..65535).
REQ-004 SHALL have parameter IDX_W, default 6, meaning width of the instance index output; the condition 2**IDX_W >= NUM_INST SHALL hold.
REQ-005 kernel_monitor_clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 kernel_monitor_reset  input  1  asynchronous, active-low reset.
REQ-007 axis_block_sigs  input  NUM_AXIS  1 = AXIS port stalled by the environment.
REQ-008 inst_idle_sigs  input  NUM_INST  1 = instance idle.
REQ-009 inst_block_sigs  input  NUM_INST  1 = instance stalled on a FIFO, stream or ap_continue.
REQ-010 clear  input  1  synchronous clear of a latched deadlock.
REQ-011 block  output  1  registered; 1 = deadlock declared (sticky).
REQ-012 watching  output  1  registered; 1 = stall window in progress.
REQ-013 first_blk_idx  output  IDX_W  lowest-numbered blocked instance, captured on declaration.
REQ-014 blk_snapshot  output  NUM_INST  inst_block_sigs captured on declaration.

Function
REQ-015 stall_now SHALL be 1 iff all of the following hold:
  - every instance has idle or block set;
  - at least one instance has block set and idle clear;
  - no axis_block_sigs bit is set (environment stalls are never deadlock).
REQ-016 FSM SHALL have three states: S_IDLE, S_WATCH and S_DEAD; a 16-bit counter cnt SHALL accompany it, together with a NUM_INST-bit register sig holding the block pattern.
REQ-017 S_IDLE with stall_now=1 SHALL enter S_WATCH, load cnt=1 and load sig=inst_block_sigs.
REQ-018 S_WATCH SHALL behave as follows:
  - stall_now=0: go to S_IDLE and set cnt=0;
  - inst_block_sigs!=sig (progress): stay in S_WATCH, set cnt=1 and reload sig;
  - otherwise: increment cnt.
REQ-019 S_WATCH with cnt==WINDOW-1, stall_now=1 and an unchanged pattern SHALL enter S_DEAD on that edge; block SHALL therefore rise on the WINDOW-th consecutive stalled cycle after the first stalled sample.
REQ-020 On entry to S_DEAD, the block SHALL capture first_blk_idx as the lowest index with block set and idle clear, and blk_snapshot as inst_block_sigs.
REQ-021 S_DEAD SHALL hold regardless of inputs until clear=1, which SHALL return the FSM to S_IDLE with cnt=0 and block=0 on the next edge; first_blk_idx and blk_snapshot SHALL hold their values.
REQ-022 clear=1 in S_IDLE or S_WATCH SHALL force S_IDLE and cnt=0; clear SHALL take priority over every other transition.
REQ-023 watching SHALL be 1 exactly in S_WATCH; block SHALL be 1 exactly in S_DEAD.
REQ-024 cnt SHALL saturate and never wrap; WINDOW=2 SHALL declare on the second consecutive stalled cycle.

Reset
REQ-025 kernel_monitor_reset=0 SHALL asynchronously force the following, irrespective of the clock:
  - state S_IDLE;
  - cnt=0, sig=0;
  - block=0, watching=0;
  - first_blk_idx=0, blk_snapshot=0.
REQ-026 Reset asserted mid-window or in S_DEAD SHALL discard all history; detection SHALL restart from S_IDLE after release.

Configuration
REQ-027 Macro DEADLOCK_MONITOR_REPORT_EN, when defined, SHALL compile in simulation reporting: on each S_DEAD entry, one line containing the simulation time, first_blk_idx and blk_snapshot in hex SHALL be printed.
REQ-028 Without DEADLOCK_MONITOR_REPORT_EN there SHALL be no printing, and port behaviour SHALL be identical to the defined case.

Verification
REQ-029 NUM_INST=4, WINDOW=16, all idle -> block=0 and watching=0 indefinitely.
REQ-030 NUM_INST=4, WINDOW=16, stimulus inst_block=4'b0110 and inst_idle=4'b1001 held constant -> watching=1 on the next edge, block=1 on the 16th stalled edge, first_blk_idx=1, blk_snapshot=4'h6.
REQ-031 Same stimulus as REQ-030 with inst_block changed to 4'b0100 at cycle 10 -> cnt restarts; block=1 only 16 stalled cycles after the change, first_blk_idx=2.
REQ-032 Same stimulus as REQ-030 with axis_block_sigs=2'b01 at cycle 8 -> S_IDLE and watching=0; block stays 0.
REQ-033 In S_DEAD, pulse clear for one cycle with the stall still present -> block=0 on the next edge, then re-declaration after 16 further cycles.
REQ-034 kernel_monitor_reset=0 asserted asynchronously at cycle 12 of a window -> block=0 and watching=0 immediately (before the next edge); full window required after release.
